// File: rtl/mod_interrupt.sv
// ---------------------------------------------------------------------------
// mod_interrupt
//   Interrupt controller for the peripheral data bus. Rising edges on the
//   source lines set pending bits; pending & MASK, gated by GIE, raises a
//   registered request to the CPU. On acknowledge the lowest active source
//   index is latched into CAUSE, its pending bit is cleared and GIE is
//   dropped so software must re-enable before the next request.
//
// Ports
//   clk_i      system clock, all state updates on the falling edge
//   rst_ni     asynchronous active-low reset
//   ie_i       instruction-bus enable (no instruction space, unused)
//   de_i       data-bus enable for this block
//   iaddr_i    instruction address (unused)
//   daddr_i    data address, [3:2] selects MASK/STATUS/CTRL/CAUSE
//   drw_i      [0] = write, [1] = read
//   din_i      write data
//   iout_o     instruction read data, always 0
//   dout_o     data read data, combinational from daddr_i while de_i
//   irq_i      raw interrupt sources, active-high, bit 0 = timer
//   int_ack_i  CPU acknowledge pulse
//   cpu_int_o  interrupt request to CPU
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request presented, cpu_int_o low
// REQ     | request presented to CPU, waiting for ack or withdrawal
// ---------------------------------------------------------------------------
module mod_interrupt #(
    parameter int unsigned NSRC = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ie_i,
    input  logic            de_i,
    input  logic [31:0]     iaddr_i,
    input  logic [31:0]     daddr_i,
    input  logic [1:0]      drw_i,
    input  logic [31:0]     din_i,
    output logic [31:0]     iout_o,
    output logic [31:0]     dout_o,
    input  logic [NSRC-1:0] irq_i,
    input  logic            int_ack_i,
    output logic            cpu_int_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [NSRC-1:0]   mask_q, mask_d;
    logic [NSRC-1:0]   pend_q, pend_d;
    logic [NSRC-1:0]   prev_q;
    logic              gie_q, gie_d;
    logic              cause_vld_q, cause_vld_d;
    logic [4:0]        cause_idx_q, cause_idx_d;

    logic              wr_mask, wr_stat, wr_ctrl;
    logic [NSRC-1:0]   edge_set, w1c, pend_kept, active, ack_active, ack_onehot;
    logic [4:0]        ack_idx;
    logic              req, ack_ok;
    logic [31:0]       mask_ext, pend_ext;

    logic unused_ok;
    assign unused_ok = ^{ie_i, iaddr_i, daddr_i[31:4], daddr_i[1:0], drw_i[1], din_i};

    assign iout_o = '0;

    always_comb begin
        wr_mask   = de_i & drw_i[0] & (daddr_i[3:2] == 2'd0);
        wr_stat   = de_i & drw_i[0] & (daddr_i[3:2] == 2'd1);
        wr_ctrl   = de_i & drw_i[0] & (daddr_i[3:2] == 2'd2);
        edge_set  = irq_i & ~prev_q;
        w1c       = wr_stat ? din_i[NSRC-1:0] : '0;
        pend_kept = pend_q & ~w1c;
        active    = pend_q & mask_q;
        req       = gie_q & (|active);
        // The ack is judged against pending after this cycle's W1C, so an
        // ack racing a software clear of the last bit is dropped and CAUSE
        // keeps its old value. A GIE write in the same cycle does not
        // cancel the ack.
        ack_active = pend_kept & mask_q;
        ack_ok     = int_ack_i & (state_q == ST_REQ) & gie_q & (|ack_active);
    end

    // Lowest index wins: scan downward so the last hit is the lowest bit.
    always_comb begin
        ack_idx    = '0;
        ack_onehot = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (ack_active[i]) begin
                ack_idx       = 5'(i);
                ack_onehot    = '0;
                ack_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        mask_d      = wr_mask ? din_i[NSRC-1:0] : mask_q;
        // New edges are OR'd last so a set beats a clear on the same bit.
        pend_d      = (pend_kept & ~(ack_ok ? ack_onehot : '0)) | edge_set;
        gie_d       = gie_q;
        if (wr_ctrl) gie_d = din_i[0];
        if (ack_ok)  gie_d = 1'b0;
        cause_vld_d = cause_vld_q;
        cause_idx_d = cause_idx_q;
        if (ack_ok) begin
            cause_vld_d = 1'b1;
            cause_idx_d = ack_idx;
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q      <= '0;
            pend_q      <= '0;
            prev_q      <= '0;
            gie_q       <= 1'b0;
            cause_vld_q <= 1'b0;
            cause_idx_q <= '0;
        end else begin
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            prev_q      <= irq_i;
            gie_q       <= gie_d;
            cause_vld_q <= cause_vld_d;
            cause_idx_q <= cause_idx_d;
        end
    end

    // FSM: state register
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_REQ;
            ST_REQ:  if (ack_ok || !req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs (decoded straight from the state flop, so glitch-free)
    always_comb begin
        cpu_int_o = (state_q == ST_REQ);
    end

    always_comb begin
        mask_ext             = '0;
        mask_ext[NSRC-1:0]   = mask_q;
        pend_ext             = '0;
        pend_ext[NSRC-1:0]   = pend_q;
        dout_o               = '0;
        if (de_i) begin
            case (daddr_i[3:2])
                2'd0:    dout_o = mask_ext;
                2'd1:    dout_o = pend_ext;
                2'd2:    dout_o = {31'd0, gie_q};
                default: dout_o = {cause_vld_q, 26'd0, cause_idx_q};
            endcase
        end
    end

endmodule

// File: tb/tb_mod_interrupt.sv
module tb_mod_interrupt;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        ie      = 1'b0;
    logic        de      = 1'b0;
    logic [31:0] iaddr   = '0;
    logic [31:0] daddr   = '0;
    logic [1:0]  drw     = '0;
    logic [31:0] din     = '0;
    logic [31:0] iout;
    logic [31:0] dout;
    logic [7:0]  irq     = '0;
    logic        int_ack = 1'b0;
    logic        cpu_int;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] A_MASK  = 32'h0;
    localparam logic [31:0] A_STAT  = 32'h4;
    localparam logic [31:0] A_CTRL  = 32'h8;
    localparam logic [31:0] A_CAUSE = 32'hC;

    mod_interrupt #(.NSRC(8)) dut (
        .clk_i     (clk_sys),
        .rst_ni    (rst_n),
        .ie_i      (ie),
        .de_i      (de),
        .iaddr_i   (iaddr),
        .daddr_i   (daddr),
        .drw_i     (drw),
        .din_i     (din),
        .iout_o    (iout),
        .dout_o    (dout),
        .irq_i     (irq),
        .int_ack_i (int_ack),
        .cpu_int_o (cpu_int)
    );

    always #10 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All stimulus starts just after a rising edge; the DUT samples on the
    // falling edge in between.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        de = 1'b1; drw = 2'b01; daddr = a; din = d;
        @(posedge clk_sys);
        de = 1'b0; drw = 2'b00; din = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        de = 1'b1; drw = 2'b10; daddr = a;
        #1;
        chk(tag, dout, exp);
        de = 1'b0; drw = 2'b00;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        @(posedge clk_sys);
        int_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_sys);
        rst_n = 1'b1;
        @(posedge clk_sys);

        // reset state
        chk_reg("rst_mask",  A_MASK,  32'h0);
        chk_reg("rst_stat",  A_STAT,  32'h0);
        chk_reg("rst_ctrl",  A_CTRL,  32'h0);
        chk_reg("rst_cause", A_CAUSE, 32'h0);
        chk("rst_cpu_int", {31'd0, cpu_int}, 32'h0);
        chk("iout_zero", iout, 32'h0);
        #1 chk("dout_no_de", dout, 32'h0);

        // 1: single timer source
        bus_write(A_MASK, 32'h1);
        bus_write(A_CTRL, 32'h1);
        irq = 8'h01;
        @(posedge clk_sys);
        irq = 8'h00;
        chk_reg("t1_stat", A_STAT, 32'h1);
        chk("t1_int_early", {31'd0, cpu_int}, 32'h0);
        @(posedge clk_sys);
        chk("t1_int_up", {31'd0, cpu_int}, 32'h1);
        ack_pulse();
        chk_reg("t1_cause", A_CAUSE, 32'h8000_0000);
        chk_reg("t1_stat_clr", A_STAT, 32'h0);
        chk_reg("t1_ctrl", A_CTRL, 32'h0);
        chk("t1_int_down", {31'd0, cpu_int}, 32'h0);

        // 2: simultaneous sources, lowest index first
        bus_write(A_MASK, 32'hFF);
        bus_write(A_CTRL, 32'h1);
        irq = 8'h28;
        @(posedge clk_sys);
        irq = 8'h00;
        @(posedge clk_sys);
        chk("t2_int_up", {31'd0, cpu_int}, 32'h1);
        ack_pulse();
        chk_reg("t2_cause3", A_CAUSE, 32'h8000_0003);
        chk_reg("t2_stat", A_STAT, 32'h20);
        chk("t2_int_down", {31'd0, cpu_int}, 32'h0);
        @(posedge clk_sys);
        chk("t2_no_gie", {31'd0, cpu_int}, 32'h0);
        bus_write(A_CTRL, 32'h1);
        @(posedge clk_sys);
        chk("t2_rereq", {31'd0, cpu_int}, 32'h1);
        ack_pulse();
        chk_reg("t2_cause5", A_CAUSE, 32'h8000_0005);
        chk_reg("t2_stat_end", A_STAT, 32'h0);

        // 3: held level sets pending only once
        irq = 8'h04;
        @(posedge clk_sys);
        chk_reg("t3_set", A_STAT, 32'h4);
        repeat (2) @(posedge clk_sys);
        bus_write(A_STAT, 32'h4);
        chk_reg("t3_w1c", A_STAT, 32'h0);
        repeat (6) @(posedge clk_sys);
        chk_reg("t3_held", A_STAT, 32'h0);
        irq = 8'h00;
        @(posedge clk_sys);
        chk_reg("t3_fall", A_STAT, 32'h0);

        // 4: edge beats W1C on the same bit
        irq = 8'h02;
        bus_write(A_STAT, 32'h2);
        chk_reg("t4_set_wins", A_STAT, 32'h2);
        irq = 8'h00;
        bus_write(A_STAT, 32'h2);
        chk_reg("t4_clr", A_STAT, 32'h0);

        // 5: withdrawal by masking, and ack racing a W1C
        bus_write(A_CTRL, 32'h1);
        irq = 8'h40;
        @(posedge clk_sys);
        irq = 8'h00;
        @(posedge clk_sys);
        chk("t5_int_up", {31'd0, cpu_int}, 32'h1);
        bus_write(A_MASK, 32'h0);
        @(posedge clk_sys);
        chk("t5_masked", {31'd0, cpu_int}, 32'h0);
        chk_reg("t5_cause_keep", A_CAUSE, 32'h8000_0005);
        bus_write(A_MASK, 32'hFF);
        @(posedge clk_sys);
        chk("t5_unmasked", {31'd0, cpu_int}, 32'h1);
        int_ack = 1'b1;
        bus_write(A_STAT, 32'h40);
        int_ack = 1'b0;
        chk_reg("t5_race_cause", A_CAUSE, 32'h8000_0005);
        chk_reg("t5_race_stat", A_STAT, 32'h0);
        chk_reg("t5_race_gie", A_CTRL, 32'h1);
        @(posedge clk_sys);
        chk("t5_race_drop", {31'd0, cpu_int}, 32'h0);

        // 6: asynchronous reset while requesting
        irq = 8'h80;
        @(posedge clk_sys);
        irq = 8'h00;
        @(posedge clk_sys);
        chk("t6_int_up", {31'd0, cpu_int}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_low", {31'd0, cpu_int}, 32'h0);
        @(posedge clk_sys);
        rst_n = 1'b1;
        chk_reg("t6_mask",  A_MASK,  32'h0);
        chk_reg("t6_stat",  A_STAT,  32'h0);
        chk_reg("t6_ctrl",  A_CTRL,  32'h0);
        chk_reg("t6_cause", A_CAUSE, 32'h0);
        @(posedge clk_sys);
        chk("t6_int_after", {31'd0, cpu_int}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
